// File: rtl/cv32e40p_ex_wb_lsu_stage.sv
// EX/WB load/store response stage: captures an access, waits for 1-2 response beats, realigns/extends load data.
// Latency: register-file write strobe one cycle after the final response beat.
// Backpressure: wb_ready_o low while a response is outstanding, but high in the completion cycle so accesses can run back-to-back.
// Optional macro FT_WB_SHADOW_EN: shadow copies of state/control fields with a sticky mismatch flag on ft_err_o.
module cv32e40p_ex_wb_lsu_stage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              wb_ready_o,
  input  logic              data_req_ex_i,
  input  logic              data_we_ex_i,
  input  logic [1:0]        data_type_ex_i,
  input  logic [1:0]        data_sign_ext_ex_i,
  input  logic [1:0]        data_reg_offset_ex_i,
  input  logic              data_split_ex_i,
  input  logic [ADDR_W-1:0] regfile_waddr_ex_i,
  input  logic              lsu_rvalid_i,
  input  logic [DATA_W-1:0] lsu_rdata_i,
  input  logic              lsu_err_i,
  output logic              regfile_we_wb_o,
  output logic [ADDR_W-1:0] regfile_waddr_wb_o,
  output logic [DATA_W-1:0] regfile_wdata_wb_o,
  output logic              load_err_o,
  output logic              busy_o,
  output logic              ft_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT1 = 2'd1, WAIT2 = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          type_q, type_d;
  logic [1:0]          sext_q, sext_d;
  logic [1:0]          off_q, off_d;
  logic                split_q, split_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                err_q, err_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                lerr_q, lerr_d;

  logic                accept, complete, final_err, ft_mismatch;
  logic [DATA_W-1:0]   hi_word, lo_word, aligned, ext_data;

  // The last beat of the access arrives this cycle; a new access may enter at the same time.
  assign complete   = lsu_rvalid_i & (((state_q == WAIT1) & ~split_q) | (state_q == WAIT2));
  assign wb_ready_o = (state_q == IDLE) | complete;
  assign accept     = ex_valid_i & wb_ready_o & data_req_ex_i;
  assign busy_o     = (state_q != IDLE);
  // A first-beat error is held in err_q; the final beat may add its own.
  assign final_err  = err_q | lsu_err_i;

  // Realign {second beat, first beat} by the byte offset, then extract and extend.
  always_comb begin
    hi_word  = (state_q == WAIT2) ? lsu_rdata_i : '0;
    lo_word  = (state_q == WAIT2) ? buf_q : lsu_rdata_i;
    aligned  = DATA_W'({hi_word, lo_word} >> {off_q, 3'b000});
    ext_data = aligned;
    case (type_q)
      2'b00: ext_data = {{(DATA_W-8){(sext_q == 2'b01) ? aligned[7] : (sext_q == 2'b10)}},
                         aligned[7:0]};
      2'b01: ext_data = {{(DATA_W-16){(sext_q == 2'b01) ? aligned[15] : (sext_q == 2'b10)}},
                         aligned[15:0]};
      default: ext_data = aligned;
    endcase
  end

  // Next-state, capture and write-back computation.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    type_d     = type_q;
    sext_d     = sext_q;
    off_d      = off_q;
    split_d    = split_q;
    waddr_d    = waddr_q;
    buf_d      = buf_q;
    err_d      = err_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    lerr_d     = 1'b0;

    case (state_q)
      WAIT1: if (lsu_rvalid_i) begin
        if (split_q) begin
          state_d = WAIT2;
          buf_d   = lsu_rdata_i;
          err_d   = err_q | lsu_err_i;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT2: if (lsu_rvalid_i) state_d = IDLE;
      default: ;
    endcase

    if (complete) begin
      lerr_d = final_err;
      if (~we_q & ~final_err & ~ft_mismatch) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = waddr_q;
        rf_wdata_d = ext_data;
      end
    end

    // A new access overrides the return-to-idle of a completing one.
    if (accept) begin
      state_d = WAIT1;
      we_d    = data_we_ex_i;
      type_d  = data_type_ex_i;
      sext_d  = data_sign_ext_ex_i;
      off_d   = data_reg_offset_ex_i;
      split_d = data_split_ex_i;
      waddr_d = regfile_waddr_ex_i;
      err_d   = 1'b0;
    end
  end

  // State, captured fields and write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      type_q     <= 2'b00;
      sext_q     <= 2'b00;
      off_q      <= 2'b00;
      split_q    <= 1'b0;
      waddr_q    <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      lerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      type_q     <= type_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      split_q    <= split_d;
      waddr_q    <= waddr_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      lerr_q     <= lerr_d;
    end
  end

  assign regfile_we_wb_o    = rf_we_q;
  assign regfile_waddr_wb_o = rf_waddr_q;
  assign regfile_wdata_wb_o = rf_wdata_q;
  assign load_err_o         = lerr_q;

`ifdef FT_WB_SHADOW_EN
  state_e            sh_state_q;
  logic              sh_we_q, sh_split_q;
  logic [1:0]        sh_type_q, sh_sext_q, sh_off_q;
  logic [ADDR_W-1:0] sh_waddr_q;
  logic              ft_err_q, ft_err_d;

  assign ft_mismatch = (sh_state_q != state_q) | (sh_we_q != we_q) | (sh_split_q != split_q) |
                       (sh_type_q != type_q) | (sh_sext_q != sext_q) | (sh_off_q != off_q) |
                       (sh_waddr_q != waddr_q);

  // Any divergence between primary and shadow copies latches the fault flag.
  always_comb begin
    ft_err_d = ft_err_q | ft_mismatch;
  end

  // Shadow copies follow the same next-state values as the primary registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_state_q <= IDLE;
      sh_we_q    <= 1'b0;
      sh_split_q <= 1'b0;
      sh_type_q  <= 2'b00;
      sh_sext_q  <= 2'b00;
      sh_off_q   <= 2'b00;
      sh_waddr_q <= '0;
      ft_err_q   <= 1'b0;
    end else begin
      sh_state_q <= state_d;
      sh_we_q    <= we_d;
      sh_split_q <= split_d;
      sh_type_q  <= type_d;
      sh_sext_q  <= sext_d;
      sh_off_q   <= off_d;
      sh_waddr_q <= waddr_d;
      ft_err_q   <= ft_err_d;
    end
  end

  assign ft_err_o = ft_err_q;
`else
  assign ft_mismatch = 1'b0;
  assign ft_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_ex_wb_lsu_stage.sv
// Bench for cv32e40p_ex_wb_lsu_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a byte-level behavioural model.
module tb_cv32e40p_ex_wb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, wb_ready_o, data_req_ex_i, data_we_ex_i;
  logic [1:0]  data_type_ex_i, data_sign_ext_ex_i, data_reg_offset_ex_i;
  logic        data_split_ex_i;
  logic [5:0]  regfile_waddr_ex_i;
  logic        lsu_rvalid_i, lsu_err_i;
  logic [31:0] lsu_rdata_i;
  logic        regfile_we_wb_o;
  logic [5:0]  regfile_waddr_wb_o;
  logic [31:0] regfile_wdata_wb_o;
  logic        load_err_o, busy_o, ft_err_o;

  int total = 0;
  int bad   = 0;
  logic last_ready;

  always #5 clk = ~clk;

  cv32e40p_ex_wb_lsu_stage #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .wb_ready_o(wb_ready_o),
    .data_req_ex_i(data_req_ex_i), .data_we_ex_i(data_we_ex_i),
    .data_type_ex_i(data_type_ex_i), .data_sign_ext_ex_i(data_sign_ext_ex_i),
    .data_reg_offset_ex_i(data_reg_offset_ex_i), .data_split_ex_i(data_split_ex_i),
    .regfile_waddr_ex_i(regfile_waddr_ex_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
    .regfile_we_wb_o(regfile_we_wb_o), .regfile_waddr_wb_o(regfile_waddr_wb_o),
    .regfile_wdata_wb_o(regfile_wdata_wb_o), .load_err_o(load_err_o),
    .busy_o(busy_o), .ft_err_o(ft_err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected load result from the response beats, treated as a little-endian byte array.
  function automatic logic [31:0] model_data(input logic [31:0] b0, input logic [31:0] b1,
                                             input logic [1:0] typ, input logic [1:0] sx,
                                             input logic [1:0] off);
    logic [7:0]  bytes [8];
    logic [31:0] v;
    int          size;
    int          o;
    for (int i = 0; i < 4; i++) begin
      bytes[i]   = b0[8*i +: 8];
      bytes[i+4] = b1[8*i +: 8];
    end
    o    = int'(off);
    size = (typ == 2'b00) ? 1 : (typ == 2'b01) ? 2 : 4;
    v    = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(bytes[o+i]) << (8*i));
    if (size < 4 && (sx == 2'b10 || (sx == 2'b01 && bytes[o+size-1][7])))
      v = v | (32'hFFFF_FFFF << (8*size));
    return v;
  endfunction

  // Behavioural model: an outstanding access with a count of beats still to come.
  bit          m_valid = 0;
  bit          m_pend;
  int          m_rem, m_nb;
  logic [31:0] m_beat [2];
  logic        m_we, m_split, m_err;
  logic [1:0]  m_typ, m_sx, m_off;
  logic [5:0]  m_waddr;
  logic        e_we, e_lerr;
  logic [5:0]  e_waddr;
  logic [31:0] e_wdata;

  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      m_valid = 1; m_pend = 0; m_rem = 0; m_nb = 0; m_err = 0;
      e_we = 0; e_lerr = 0; e_waddr = '0; e_wdata = '0;
    end else if (m_valid) begin
      rdy    = !m_pend || (lsu_rvalid_i && m_rem == 1);
      e_we   = 0;
      e_lerr = 0;
      if (m_pend && lsu_rvalid_i) begin
        m_beat[m_nb] = lsu_rdata_i;
        m_nb++;
        m_err = m_err | lsu_err_i;
        m_rem--;
        if (m_rem == 0) begin
          m_pend = 0;
          if (m_err) e_lerr = 1;
          else if (!m_we) begin
            e_we    = 1;
            e_waddr = m_waddr;
            e_wdata = model_data(m_beat[0], (m_nb == 2) ? m_beat[1] : 32'h0, m_typ, m_sx, m_off);
          end
        end
      end
      if (ex_valid_i && rdy && data_req_ex_i) begin
        m_pend = 1; m_rem = data_split_ex_i ? 2 : 1; m_nb = 0; m_err = 0;
        m_we = data_we_ex_i; m_typ = data_type_ex_i; m_sx = data_sign_ext_ex_i;
        m_off = data_reg_offset_ex_i; m_split = data_split_ex_i; m_waddr = regfile_waddr_ex_i;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready", 32'(wb_ready_o), 32'(!m_pend || (lsu_rvalid_i && m_rem == 1)));
      chk("busy",  32'(busy_o), 32'(m_pend));
      chk("we",    32'(regfile_we_wb_o), 32'(e_we));
      chk("lerr",  32'(load_err_o), 32'(e_lerr));
      chk("waddr", 32'(regfile_waddr_wb_o), 32'(e_waddr));
      chk("wdata", regfile_wdata_wb_o, e_wdata);
`ifndef FT_WB_SHADOW_EN
      chk("ft_err", 32'(ft_err_o), 32'h0);
`endif
    end
  end

  task automatic drive(input logic r, input logic ev, input logic req, input logic we,
                       input logic [1:0] typ, input logic [1:0] sx, input logic [1:0] off,
                       input logic sp, input logic [5:0] wa, input logic rv,
                       input logic [31:0] rd, input logic er);
    rst = r; ex_valid_i = ev; data_req_ex_i = req; data_we_ex_i = we;
    data_type_ex_i = typ; data_sign_ext_ex_i = sx; data_reg_offset_ex_i = off;
    data_split_ex_i = sp; regfile_waddr_ex_i = wa;
    lsu_rvalid_i = rv; lsu_rdata_i = rd; lsu_err_i = er;
    #2;
    last_ready = wb_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 6'd0, 0, 32'h0, 0);
  endtask

  task automatic resp(input logic [31:0] rd, input logic er);
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 6'd0, 1, rd, er);
  endtask

  initial begin
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 6'd0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 6'd0, 0, 32'h0, 0);
    idle();
    chk("rst_ready", 32'(wb_ready_o), 32'h1);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_wdata", regfile_wdata_wb_o, 32'h0);

    // Aligned word load, response three cycles after accept.
    drive(0, 1, 1, 0, 2'd2, 2'd0, 2'd0, 0, 6'd5, 0, 32'h0, 0);
    idle();
    chk("word_wait_ready", 32'(last_ready), 32'h0);
    idle();
    resp(32'hDEADBEEF, 0);
    chk("word_done_ready", 32'(last_ready), 32'h1);
    chk("word_we", 32'(regfile_we_wb_o), 32'h1);
    chk("word_waddr", 32'(regfile_waddr_wb_o), 32'd5);
    chk("word_wdata", regfile_wdata_wb_o, 32'hDEADBEEF);
    idle();
    chk("word_we_pulse", 32'(regfile_we_wb_o), 32'h0);

    // Signed and unsigned byte at offset 3.
    drive(0, 1, 1, 0, 2'd0, 2'd1, 2'd3, 0, 6'd6, 0, 32'h0, 0);
    resp(32'h80AA5511, 0);
    chk("sbyte_wdata", regfile_wdata_wb_o, 32'hFFFFFF80);
    drive(0, 1, 1, 0, 2'd0, 2'd0, 2'd3, 0, 6'd6, 0, 32'h0, 0);
    resp(32'h80AA5511, 0);
    chk("ubyte_wdata", regfile_wdata_wb_o, 32'h00000080);

    // Split word load at offset 2.
    drive(0, 1, 1, 0, 2'd2, 2'd0, 2'd2, 1, 6'd8, 0, 32'h0, 0);
    resp(32'h33441122, 0);
    chk("split_first_we", 32'(regfile_we_wb_o), 32'h0);
    resp(32'h77885566, 0);
    chk("split_we", 32'(regfile_we_wb_o), 32'h1);
    chk("split_wdata", regfile_wdata_wb_o, 32'h55663344);

    // Store, then a load accepted in the store's completion cycle.
    drive(0, 1, 1, 1, 2'd2, 2'd0, 2'd0, 0, 6'd9, 0, 32'h0, 0);
    drive(0, 1, 1, 0, 2'd2, 2'd0, 2'd0, 0, 6'd7, 1, 32'hCAFEF00D, 0);
    chk("b2b_ready", 32'(last_ready), 32'h1);
    chk("store_no_we", 32'(regfile_we_wb_o), 32'h0);
    chk("b2b_busy", 32'(busy_o), 32'h1);
    resp(32'h12345678, 0);
    chk("b2b_we", 32'(regfile_we_wb_o), 32'h1);
    chk("b2b_waddr", 32'(regfile_waddr_wb_o), 32'd7);
    chk("b2b_wdata", regfile_wdata_wb_o, 32'h12345678);

    // Error on the first beat of a split load.
    drive(0, 1, 1, 0, 2'd2, 2'd0, 2'd1, 1, 6'd3, 0, 32'h0, 0);
    resp(32'h11111111, 1);
    chk("err_first_lerr", 32'(load_err_o), 32'h0);
    resp(32'h22222222, 0);
    chk("err_lerr", 32'(load_err_o), 32'h1);
    chk("err_no_we", 32'(regfile_we_wb_o), 32'h0);
    idle();
    chk("err_pulse", 32'(load_err_o), 32'h0);

    // Reset while waiting, then a stray response.
    drive(0, 1, 1, 0, 2'd2, 2'd0, 2'd0, 0, 6'd4, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 6'd0, 0, 32'h0, 0);
    resp(32'hAAAAAAAA, 0);
    chk("stray_we", 32'(regfile_we_wb_o), 32'h0);
    chk("stray_busy", 32'(busy_o), 32'h0);
    chk("stray_ready", 32'(wb_ready_o), 32'h1);
    chk("stray_wdata", regfile_wdata_wb_o, 32'h0);
    chk("stray_lerr", 32'(load_err_o), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), 6'($urandom), ($urandom_range(0, 4) < 2),
            $urandom, ($urandom_range(0, 9) == 0));
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
